// File: rtl/dut_vector_sequencer.sv
// Clocked stimulus sequencer for a combinational DUT: fetches vectors, drives them,
// waits a settle window, writes the captured result and counts golden mismatches.
module dut_vector_sequencer #(
   parameter int DATA_W = 2,
   parameter int ADDR_W = 4,
   parameter int SETTLE = 1,
   parameter int ERR_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W:0]   num_vec,
   output logic [ADDR_W-1:0] vec_addr,
   input  logic [DATA_W-1:0] vec_data,
   input  logic [DATA_W-1:0] gold_data,
   output logic [DATA_W-1:0] dut_in,
   input  logic [DATA_W-1:0] dut_out,
   output logic              res_we,
   output logic [ADDR_W-1:0] res_addr,
   output logic [DATA_W-1:0] res_data,
   output logic              busy,
   output logic              done,
   output logic [ERR_W-1:0]  err_cnt
);

   localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
   localparam logic [SW-1:0] SETTLE_V = SW'(SETTLE);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_APPLY,
      S_WAIT,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t            state;
   state_t            next_state;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W:0]   num_q;
   logic [ADDR_W:0]   idx_inc;
   logic              last_vec;
   logic [DATA_W-1:0] gold_q;
   logic [SW-1:0]     settle_cnt;

   // Widened increment so a full 2**ADDR_W run ends on the all-ones index without wrapping.
   assign idx_inc  = {1'b0, idx} + {{ADDR_W{1'b0}}, 1'b1};
   assign last_vec = (idx_inc == num_q);

   assign res_we = (state == S_CAPTURE) && !abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      if (abort) begin
         next_state = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  next_state = (num_vec == '0) ? S_DONE : S_FETCH;
               end
            end
            S_FETCH:   next_state = S_APPLY;
            S_APPLY:   next_state = (SETTLE > 0) ? S_WAIT : S_CAPTURE;
            S_WAIT: begin
               if (settle_cnt == SW'(1)) begin
                  next_state = S_CAPTURE;
               end
            end
            S_CAPTURE: next_state = last_vec ? S_DONE : S_FETCH;
            S_DONE:    next_state = S_IDLE;
            default:   next_state = S_IDLE;
         endcase
      end
   end

   // Result address/data are loaded on entry to CAPTURE so the write strobe sees stable values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_addr   <= '0;
         dut_in     <= '0;
         res_addr   <= '0;
         res_data   <= '0;
         err_cnt    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         idx        <= '0;
         num_q      <= '0;
         gold_q     <= '0;
         settle_cnt <= '0;
      end else begin
         busy <= (next_state != S_IDLE);
         done <= (state == S_DONE) && !abort;
         if (!abort) begin
            if ((next_state == S_CAPTURE) && (state != S_CAPTURE)) begin
               res_addr <= idx;
               res_data <= dut_out;
            end
            case (state)
               S_IDLE: begin
                  if (start) begin
                     num_q    <= num_vec;
                     idx      <= '0;
                     vec_addr <= '0;
                     err_cnt  <= '0;
                  end
               end
               S_APPLY: begin
                  dut_in     <= vec_data;
                  gold_q     <= gold_data;
                  settle_cnt <= SETTLE_V;
               end
               S_WAIT: begin
                  settle_cnt <= settle_cnt - SW'(1);
               end
               S_CAPTURE: begin
                  if ((res_data != gold_q) && (err_cnt != {ERR_W{1'b1}})) begin
                     err_cnt <= err_cnt + {{(ERR_W-1){1'b0}}, 1'b1};
                  end
                  if (!last_vec) begin
                     idx      <= idx_inc[ADDR_W-1:0];
                     vec_addr <= idx_inc[ADDR_W-1:0];
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dut_vector_sequencer.sv
// Directed bench for dut_vector_sequencer: behavioural memories and DUT model around the
// sequencer, table-driven result checks plus hand-written reset/abort/saturation sequences.
module tb_dut_vector_sequencer;

   localparam int DATA_W = 2;
   localparam int ADDR_W = 4;
   localparam int SETTLE = 1;
   localparam int ERR_W  = 3;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic              abort;
   logic [ADDR_W:0]   num_vec;
   logic [ADDR_W-1:0] vec_addr;
   logic [DATA_W-1:0] vec_data;
   logic [DATA_W-1:0] gold_data;
   logic [DATA_W-1:0] dut_in;
   logic [DATA_W-1:0] dut_out;
   logic              res_we;
   logic [ADDR_W-1:0] res_addr;
   logic [DATA_W-1:0] res_data;
   logic              busy;
   logic              done;
   logic [ERR_W-1:0]  err_cnt;

   logic [DATA_W-1:0] stim_mem [0:15];
   logic [DATA_W-1:0] gold_mem [0:15];
   logic [DATA_W-1:0] res_mem  [0:15];
   int                wr_count;
   int                last_wr_addr;

   int total;
   int bad;

   typedef struct {
      logic [DATA_W-1:0] stim;
      logic [DATA_W-1:0] gold;
      logic [DATA_W-1:0] exp_res;
   } vec_t;

   vec_t tbl [4];

   dut_vector_sequencer #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .SETTLE(SETTLE),
      .ERR_W (ERR_W)
   ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .abort    (abort),
      .num_vec  (num_vec),
      .vec_addr (vec_addr),
      .vec_data (vec_data),
      .gold_data(gold_data),
      .dut_in   (dut_in),
      .dut_out  (dut_out),
      .res_we   (res_we),
      .res_addr (res_addr),
      .res_data (res_data),
      .busy     (busy),
      .done     (done),
      .err_cnt  (err_cnt)
   );

   // Combinational device under sequencing: out[0]=~in[0], out[1]=~in[0]^in[1].
   function automatic logic [DATA_W-1:0] dutModel(input logic [DATA_W-1:0] din);
      return {~din[0] ^ din[1], ~din[0]};
   endfunction

   assign dut_out = dutModel(dut_in);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read stimulus and golden memories sharing one address.
   always @(posedge clk) begin
      vec_data  <= stim_mem[vec_addr];
      gold_data <= gold_mem[vec_addr];
   end

   always @(posedge clk) begin
      if (rst_n && res_we) begin
         res_mem[res_addr] <= res_data;
         wr_count          <= wr_count + 1;
         last_wr_addr      <= int'(res_addr);
      end
   end

   initial begin
      wr_count     = 0;
      last_wr_addr = -1;
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   task automatic loadTable();
      for (int i = 0; i < 4; i++) begin
         stim_mem[i] = tbl[i].stim;
         gold_mem[i] = tbl[i].gold;
      end
   endtask

   // Starts a run, returns edges from the accepting edge to the edge that shows done.
   task automatic applyStimulus(input int n, input string tag, output int lat);
      int seen;
      num_vec = (ADDR_W+1)'(n);
      start   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat   = 0;
      seen  = 0;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk);
         #1;
         lat++;
         if (done) begin
            seen = 1;
            break;
         end
      end
      checkOutput({tag, "_done_seen"}, seen, 1);
      if (seen == 1) begin
         checkOutput({tag, "_busy_low_at_done"}, int'(busy), 0);
         @(posedge clk);
         #1;
         checkOutput({tag, "_done_width"}, int'(done), 0);
      end
   endtask

   initial begin
      int lat;
      int wb;
      int found;
      int done_hits;
      total   = 0;
      bad     = 0;
      rst_n   = 1'b0;
      start   = 1'b0;
      abort   = 1'b0;
      num_vec = '0;
      for (int i = 0; i < 16; i++) begin
         stim_mem[i] = '0;
         gold_mem[i] = '0;
      end

      // Hand-computed from the DUT model: 00->11, 01->00, 10->01, 11->10.
      tbl[0] = '{stim: 2'b00, gold: 2'b11, exp_res: 2'b11};
      tbl[1] = '{stim: 2'b01, gold: 2'b00, exp_res: 2'b00};
      tbl[2] = '{stim: 2'b10, gold: 2'b01, exp_res: 2'b01};
      tbl[3] = '{stim: 2'b11, gold: 2'b10, exp_res: 2'b10};

      #2;
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_done", int'(done), 0);
      checkOutput("rst_res_we", int'(res_we), 0);
      checkOutput("rst_err_cnt", int'(err_cnt), 0);
      checkOutput("rst_dut_in", int'(dut_in), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Clean 4-vector run, all golden matches.
      loadTable();
      wb = wr_count;
      applyStimulus(4, "t2", lat);
      checkOutput("t2_latency", lat, 17);
      checkOutput("t2_err_cnt", int'(err_cnt), 0);
      checkOutput("t2_writes", wr_count - wb, 4);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("t2_res%0d", i), int'(res_mem[i]), int'(tbl[i].exp_res));
      end

      // Corrupted golden entry 2: one miscompare, written results unchanged.
      tbl[2].gold = 2'b11;
      loadTable();
      wb = wr_count;
      applyStimulus(4, "t3", lat);
      checkOutput("t3_err_cnt", int'(err_cnt), 1);
      checkOutput("t3_writes", wr_count - wb, 4);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("t3_res%0d", i), int'(res_mem[i]), int'(tbl[i].exp_res));
      end
      tbl[2].gold = 2'b01;

      // Empty run goes straight to DONE and clears the previous error count.
      wb = wr_count;
      applyStimulus(0, "t4", lat);
      checkOutput("t4_latency", lat, 1);
      checkOutput("t4_writes", wr_count - wb, 0);
      checkOutput("t4_err_cnt", int'(err_cnt), 0);

      // Full-depth run with every golden entry wrong: counter saturates, index stops at 15.
      for (int i = 0; i < 16; i++) begin
         stim_mem[i] = DATA_W'(i);
         gold_mem[i] = ~dutModel(DATA_W'(i));
      end
      wb = wr_count;
      applyStimulus(16, "t5", lat);
      checkOutput("t5_latency", lat, 65);
      checkOutput("t5_err_cnt_sat", int'(err_cnt), 7);
      checkOutput("t5_writes", wr_count - wb, 16);
      checkOutput("t5_last_wr_addr", last_wr_addr, 15);
      checkOutput("t5_vec_addr_nowrap", int'(vec_addr), 15);
      checkOutput("t5_res15", int'(res_mem[15]), int'(dutModel(2'b11)));

      // Reset asserted in the WAIT of vector 2.
      loadTable();
      num_vec = 5'd4;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      checkOutput("t1_pre_busy", int'(busy), 1);
      checkOutput("t1_pre_dut_in", int'(dut_in), 2);
      wb    = wr_count;
      rst_n = 1'b0;
      #1;
      checkOutput("t1_busy", int'(busy), 0);
      checkOutput("t1_dut_in", int'(dut_in), 0);
      checkOutput("t1_vec_addr", int'(vec_addr), 0);
      checkOutput("t1_res_addr", int'(res_addr), 0);
      checkOutput("t1_res_data", int'(res_data), 0);
      checkOutput("t1_res_we", int'(res_we), 0);
      checkOutput("t1_done", int'(done), 0);
      checkOutput("t1_err_cnt", int'(err_cnt), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("t1_idle_after", int'(busy), 0);
      checkOutput("t1_no_writes", wr_count - wb, 0);

      // Abort in the CAPTURE of vector 1, then a clean rerun.
      num_vec = 5'd4;
      wb      = wr_count;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      found = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (res_we && (res_addr == 4'd1)) begin
            found = 1;
            break;
         end
      end
      checkOutput("t6_capture_seen", found, 1);
      abort = 1'b1;
      #1;
      checkOutput("t6_we_forced_low", int'(res_we), 0);
      @(posedge clk);
      #1;
      abort = 1'b0;
      checkOutput("t6_busy", int'(busy), 0);
      checkOutput("t6_writes", wr_count - wb, 1);
      checkOutput("t6_dut_in_kept", int'(dut_in), 1);
      checkOutput("t6_err_cnt_kept", int'(err_cnt), 0);
      done_hits = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         if (done || busy) done_hits++;
      end
      checkOutput("t6_stays_idle", done_hits, 0);
      wb = wr_count;
      applyStimulus(4, "t6b", lat);
      checkOutput("t6b_latency", lat, 17);
      checkOutput("t6b_writes", wr_count - wb, 4);
      checkOutput("t6b_err_cnt", int'(err_cnt), 0);
      checkOutput("t6b_res1", int'(res_mem[1]), int'(tbl[1].exp_res));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
